// File: rtl/instr_encoder_loader.sv
// X9 instruction loader: encodes symbolic instruction beats into 9-bit machine words
// and writes them sequentially into instruction memory starting at address 0.
module instr_encoder_loader #(
    parameter int AW = 8
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_mnem,
    input  logic [3:0]    in_fa,
    input  logic [3:0]    in_fb,
    input  logic          in_last,
    output logic          im_we,
    output logic [AW-1:0] im_addr,
    output logic [8:0]    im_wdata,
    output logic [AW:0]   prog_len,
    output logic [8:0]    checksum,
    output logic          busy,
    output logic          prog_done,
    output logic          err_illegal,
    output logic          err_ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_ptr;
    logic [AW:0]   r_len;
    logic [8:0]    r_cks;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [8:0]    r_wdata;
    logic          r_err_ill;
    logic          r_err_ovf;

    logic          w_accept;
    logic          w_legal;
    logic          w_full;
    logic [8:0]    w_word;

    // Mnemonics 0-15 carry their own opcode; movr/movi use the 2-bit 1x prefix space.
    always_comb begin
        w_word  = '0;
        w_legal = 1'b0;
        if (!in_mnem[4]) begin
            w_word  = {in_mnem, in_fa};
            w_legal = 1'b1;
        end else if (in_mnem == 5'd16) begin
            w_word  = {2'b10, in_fa, in_fb[2:0]};
            w_legal = !in_fb[3];
        end else if (in_mnem == 5'd17) begin
            w_word  = {2'b11, in_fa[2:0], in_fb};
            w_legal = !in_fa[3];
        end
    end

    assign in_ready = (r_state == S_LOAD) && !start;
    assign w_accept = in_valid && in_ready;
    assign w_full   = &r_ptr;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_LOAD;
            S_LOAD: begin
                if (start)
                    w_state_nxt = S_LOAD;
                else if (w_accept && (in_last || (w_legal && w_full)))
                    w_state_nxt = S_DONE;
            end
            S_DONE: if (start) w_state_nxt = S_LOAD;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Write port, pointer, length and checksum all update on the accept edge,
    // so the word appears on the memory port the cycle after acceptance.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ptr     <= '0;
            r_len     <= '0;
            r_cks     <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_err_ill <= 1'b0;
            r_err_ovf <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (start) begin
                r_ptr     <= '0;
                r_len     <= '0;
                r_cks     <= '0;
                r_err_ill <= 1'b0;
                r_err_ovf <= 1'b0;
            end else if (w_accept) begin
                if (w_legal) begin
                    r_we    <= 1'b1;
                    r_addr  <= r_ptr;
                    r_wdata <= w_word;
                    r_ptr   <= r_ptr + AW'(1);
                    r_len   <= r_len + (AW+1)'(1);
                    r_cks   <= r_cks ^ w_word;
                    if (w_full && !in_last) r_err_ovf <= 1'b1;
                end else begin
                    r_err_ill <= 1'b1;
                end
            end
        end
    end

    assign im_we       = r_we;
    assign im_addr     = r_addr;
    assign im_wdata    = r_wdata;
    assign prog_len    = r_len;
    assign checksum    = r_cks;
    assign busy        = (r_state == S_LOAD);
    assign prog_done   = (r_state == S_DONE);
    assign err_illegal = r_err_ill;
    assign err_ovf     = r_err_ovf;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: a full-size (AW=8) and a tiny (AW=2) instance, directed
// scenarios followed by random beats, every cycle compared against a transaction-level model.
module tb_instr_encoder_loader;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       b_start, b_valid, b_ready, b_last, b_we, b_busy, b_done, b_ei, b_eo;
    logic [4:0] b_mnem;
    logic [3:0] b_fa, b_fb;
    logic [7:0] b_addr;
    logic [8:0] b_wdata, b_len, b_cks;

    logic       s_start, s_valid, s_ready, s_last, s_we, s_busy, s_done, s_ei, s_eo;
    logic [4:0] s_mnem;
    logic [3:0] s_fa, s_fb;
    logic [1:0] s_addr;
    logic [2:0] s_len;
    logic [8:0] s_wdata, s_cks;

    instr_encoder_loader #(.AW(8)) u_big (
        .Clk(clk), .Reset_n(rst_n), .start(b_start), .in_valid(b_valid), .in_ready(b_ready),
        .in_mnem(b_mnem), .in_fa(b_fa), .in_fb(b_fb), .in_last(b_last),
        .im_we(b_we), .im_addr(b_addr), .im_wdata(b_wdata), .prog_len(b_len), .checksum(b_cks),
        .busy(b_busy), .prog_done(b_done), .err_illegal(b_ei), .err_ovf(b_eo)
    );

    instr_encoder_loader #(.AW(2)) u_small (
        .Clk(clk), .Reset_n(rst_n), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
        .in_mnem(s_mnem), .in_fa(s_fa), .in_fb(s_fb), .in_last(s_last),
        .im_we(s_we), .im_addr(s_addr), .im_wdata(s_wdata), .prog_len(s_len), .checksum(s_cks),
        .busy(s_busy), .prog_done(s_done), .err_illegal(s_ei), .err_ovf(s_eo)
    );

    int checks = 0;
    int failures = 0;

    // per-instance stimulus for the current cycle
    bit st[2], vl[2], ls[2];
    int mn[2], fa[2], fb[2];

    // reference model: 0 idle, 1 loading, 2 done
    int depth[2] = '{256, 4};
    int m_state[2], m_ptr[2], m_len[2], m_cks[2], m_addr[2], m_wdata[2];
    bit m_we[2], m_ei[2], m_eo[2];
    string onm[9] = '{"we", "addr", "wdata", "len", "cks", "busy", "done", "err_ill", "err_ovf"};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void enc(input int m, input int a, input int b, output bit lg, output int w);
        lg = 1'b0;
        w  = 0;
        if (m < 16) begin
            lg = 1'b1; w = m * 16 + a;
        end else if (m == 16) begin
            lg = (b < 8); w = 256 + a * 8 + (b % 8);
        end else if (m == 17) begin
            lg = (a < 8); w = 384 + (a % 8) * 16 + b;
        end
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_state[d] = 0; m_ptr[d] = 0; m_len[d] = 0; m_cks[d] = 0;
            m_addr[d] = 0; m_wdata[d] = 0; m_we[d] = 0; m_ei[d] = 0; m_eo[d] = 0;
        end
    endtask

    task automatic model_step(input int d, input bit acc);
        bit lg;
        int w;
        m_we[d] = 1'b0;
        if (st[d]) begin
            m_state[d] = 1; m_ptr[d] = 0; m_len[d] = 0; m_cks[d] = 0; m_ei[d] = 0; m_eo[d] = 0;
        end else if (acc) begin
            enc(mn[d], fa[d], fb[d], lg, w);
            if (lg) begin
                m_we[d] = 1'b1; m_addr[d] = m_ptr[d]; m_wdata[d] = w;
                m_len[d] = m_len[d] + 1;
                m_cks[d] = m_cks[d] ^ w;
                if (m_ptr[d] == depth[d] - 1) begin
                    m_state[d] = 2;
                    if (!ls[d]) m_eo[d] = 1'b1;
                end
                m_ptr[d] = (m_ptr[d] + 1) % depth[d];
            end else begin
                m_ei[d] = 1'b1;
            end
            if (ls[d]) m_state[d] = 2;
        end
    endtask

    task automatic check_outs(input int d);
        logic [31:0] o[9];
        logic [31:0] e[9];
        if (d == 0) begin
            o[0] = 32'(b_we); o[1] = 32'(b_addr); o[2] = 32'(b_wdata); o[3] = 32'(b_len);
            o[4] = 32'(b_cks); o[5] = 32'(b_busy); o[6] = 32'(b_done); o[7] = 32'(b_ei); o[8] = 32'(b_eo);
        end else begin
            o[0] = 32'(s_we); o[1] = 32'(s_addr); o[2] = 32'(s_wdata); o[3] = 32'(s_len);
            o[4] = 32'(s_cks); o[5] = 32'(s_busy); o[6] = 32'(s_done); o[7] = 32'(s_ei); o[8] = 32'(s_eo);
        end
        e[0] = 32'(m_we[d]); e[1] = m_addr[d]; e[2] = m_wdata[d]; e[3] = m_len[d]; e[4] = m_cks[d];
        e[5] = 32'(m_state[d] == 1); e[6] = 32'(m_state[d] == 2); e[7] = 32'(m_ei[d]); e[8] = 32'(m_eo[d]);
        for (int i = 0; i < 9; i++)
            chk($sformatf("%s.%s", (d == 0) ? "big" : "small", onm[i]), o[i], e[i]);
    endtask

    task automatic apply();
        b_start = st[0]; b_valid = vl[0]; b_last = ls[0];
        b_mnem = 5'(mn[0]); b_fa = 4'(fa[0]); b_fb = 4'(fb[0]);
        s_start = st[1]; s_valid = vl[1]; s_last = ls[1];
        s_mnem = 5'(mn[1]); s_fa = 4'(fa[1]); s_fb = 4'(fb[1]);
    endtask

    // One clock: ready checked mid-cycle, registered outputs checked just after the edge.
    task automatic tick();
        bit acc[2];
        bit er;
        apply();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            er = (m_state[d] == 1) && !st[d];
            chk((d == 0) ? "big.in_ready" : "small.in_ready", 32'((d == 0) ? b_ready : s_ready), 32'(er));
            acc[d] = vl[d] && er;
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_step(d, acc[d]);
        #1;
        for (int d = 0; d < 2; d++) check_outs(d);
    endtask

    task automatic set_idle(input int d);
        st[d] = 0; vl[d] = 0; ls[d] = 0; mn[d] = 0; fa[d] = 0; fb[d] = 0;
    endtask

    task automatic beat(input int d, input bit s, input bit v, input int m, input int a, input int b, input bit l);
        set_idle(1 - d);
        st[d] = s; vl[d] = v; mn[d] = m; fa[d] = a; fb[d] = b; ls[d] = l;
        tick();
    endtask

    task automatic idle(input int n);
        set_idle(0);
        set_idle(1);
        repeat (n) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        set_idle(0);
        set_idle(1);
        model_reset();
        apply();
        #17;
        check_outs(0);
        check_outs(1);
        chk("reset.in_ready", 32'(b_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // 1: add fa=3, movi fa=2 fb=9 last
        beat(0, 1, 0, 0, 0, 0, 0);
        beat(0, 0, 1, 0, 3, 0, 0);
        chk("t1.w0", 32'(b_wdata), 32'h003);
        beat(0, 0, 1, 17, 2, 9, 1);
        chk("t1.w1", 32'(b_wdata), 32'h1A9);
        chk("t1.addr", 32'(b_addr), 32'd1);
        chk("t1.len", 32'(b_len), 32'd2);
        chk("t1.cks", 32'(b_cks), 32'h1AA);
        chk("t1.done", 32'(b_done), 32'd1);
        idle(2);

        // 2: four back-to-back legal beats
        beat(0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            beat(0, 0, 1, i + 4, i, 0, i == 3);
            chk("t2.we", 32'(b_we), 32'd1);
            chk("t2.addr", 32'(b_addr), 32'(i));
        end
        idle(1);

        // 3: illegal movr and mnem 20, then a legal beat at address 0
        beat(0, 1, 0, 0, 0, 0, 0);
        beat(0, 0, 1, 16, 5, 8, 0);
        chk("t3.we_movr", 32'(b_we), 32'd0);
        beat(0, 0, 1, 20, 1, 1, 0);
        chk("t3.err", 32'(b_ei), 32'd1);
        chk("t3.len", 32'(b_len), 32'd0);
        beat(0, 0, 1, 2, 7, 0, 1);
        chk("t3.addr", 32'(b_addr), 32'd0);
        chk("t3.we", 32'(b_we), 32'd1);
        idle(1);

        // 4: small instance overflows after four writes
        beat(1, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) beat(1, 0, 1, i + 1, i, 0, 0);
        chk("t4.ovf", 32'(s_eo), 32'd1);
        chk("t4.len", 32'(s_len), 32'd4);
        chk("t4.done", 32'(s_done), 32'd1);
        chk("t4.we5", 32'(s_we), 32'd0);
        idle(1);

        // 5: start during a load blocks that beat and clears errors/checksum
        beat(0, 1, 0, 0, 0, 0, 0);
        beat(0, 0, 1, 31, 0, 0, 0);
        beat(0, 0, 1, 9, 9, 0, 0);
        beat(0, 1, 1, 3, 3, 0, 0);
        chk("t5.err_clr", 32'(b_ei), 32'd0);
        chk("t5.cks_clr", 32'(b_cks), 32'd0);
        beat(0, 0, 1, 5, 1, 0, 0);
        chk("t5.addr", 32'(b_addr), 32'd0);
        chk("t5.cks", 32'(b_cks), 32'h051);
        idle(1);

        // random programs on both instances at once
        for (int n = 0; n < 600; n++) begin
            for (int d = 0; d < 2; d++) begin
                st[d] = ($urandom_range(0, 24) == 0);
                if (m_state[d] != 1 && $urandom_range(0, 2) == 0) st[d] = 1;
                vl[d] = ($urandom_range(0, 3) != 0);
                mn[d] = ($urandom_range(0, 3) == 0) ? $urandom_range(16, 31) : $urandom_range(0, 17);
                fa[d] = $urandom_range(0, 15);
                fb[d] = $urandom_range(0, 15);
                ls[d] = ($urandom_range(0, 9) == 0);
            end
            tick();
        end

        // 6: asynchronous reset while a write is on the port
        idle(1);
        beat(0, 1, 0, 0, 0, 0, 0);
        beat(0, 0, 1, 1, 1, 0, 0);
        chk("t6.we_before", 32'(b_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_outs(0);
        check_outs(1);
        chk("t6.in_ready", 32'(b_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        beat(0, 0, 1, 1, 1, 0, 0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
